// File: rtl/arf086b128e1r1w0cbbehsaa4acw_wr_stage.sv
// Write stage for a phase-B latch array. After reset or an init request it
// zero-fills every word, one word per cycle. It then stages one write per
// cycle into a single-hot, active-low latch enable and a shared data bus.
// All outputs are registered.
module arf086b128e1r1w0cbbehsaa4acw_wr_stage #(
  parameter int DWIDTH = 86,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              init_req,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DEPTH-1:0]  lat_wen_b,
  output logic [DWIDTH-1:0] lat_wdata,
  output logic              init_done,
  output logic              addr_err
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [AWIDTH-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]   wen_q, wen_d;
  logic [DWIDTH-1:0]  wdata_q, wdata_d;
  logic               rdy_q, rdy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [AWIDTH-1:0]  fill_idx;
  logic               wr_acc;
  logic               addr_ok;

  assign wr_acc  = wr_vld & rdy_q;
  // Addresses are compared at 32 bits so that a non-power-of-two DEPTH
  // still flags the unused top of the address space.
  assign addr_ok = ({{(32-AWIDTH){1'b0}}, wr_addr} < DEPTH);

  // Compute the next state and the next staged latch enables and data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = '1;
    wdata_d  = wdata_q;
    rdy_d    = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    fill_idx = '0;
    case (state_q)
      S_INIT: begin
        // An init request during fill restarts the fill, so word 0 is driven next.
        fill_idx          = init_req ? '0 : cnt_q;
        wen_d[fill_idx]   = 1'b0;
        wdata_d           = '0;
        done_d            = 1'b0;
        if (!init_req && cnt_q == AWIDTH'(DEPTH - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = fill_idx + AWIDTH'(1);
        end
      end
      S_RUN: begin
        if (wr_acc) begin
          if (addr_ok) begin
            wen_d[wr_addr] = 1'b0;
            wdata_d        = wr_data;
          end else begin
            err_d          = 1'b1;
          end
        end
        // A write accepted alongside init_req still completes next cycle.
        // Fill then starts one cycle later.
        if (init_req) begin
          state_d = S_INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Register the state and all outputs. Reset is synchronous and discards any staged write.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      wen_q   <= '1;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_rdy    = rdy_q;
  assign lat_wen_b = wen_q;
  assign lat_wdata = wdata_q;
  assign init_done = done_q;
  assign addr_err  = err_q;

endmodule
